// File: rtl/vga_pkg.sv
// vga_pkg: shared widths, starvation limit and arbiter state encoding for the character RAM path.
package vga_pkg;
    localparam int VGA_ADDR_W       = 12;
    localparam int VGA_DATA_W       = 8;
    localparam int VGA_STARVE_LIMIT = 800;
    localparam int FCNT_W           = 16;
    typedef enum logic [1:0] {IDLE, READ, WRITE, FORCE} arb_state_t;
endpackage

// File: rtl/char_ram_arbiter_if.sv
// char_ram_arbiter_if: video read, update write and single-port RAM signals of the character arbiter.
interface char_ram_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              vid_rd_en;
    logic [ADDR_W-1:0] vid_addr;
    logic [DATA_W-1:0] vid_data;
    logic              vid_valid;
    logic              vid_stale;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic [15:0]       forced_cnt;
    modport master (
        output vid_rd_en, vid_addr, wr_req, wr_addr, wr_data, mem_rdata,
        input  vid_data, vid_valid, vid_stale, wr_ack, mem_addr, mem_wdata, mem_we, forced_cnt
    );
    modport slave (
        input  vid_rd_en, vid_addr, wr_req, wr_addr, wr_data, mem_rdata,
        output vid_data, vid_valid, vid_stale, wr_ack, mem_addr, mem_wdata, mem_we, forced_cnt
    );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: up-counter with synchronous clear that sticks at LIMIT instead of wrapping.
module sat_counter #(
    parameter int W     = 16,
    parameter int LIMIT = 65535
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);
    logic [W-1:0] r_cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_inc && r_cnt != W'(LIMIT))
            r_cnt <= r_cnt + 1'b1;
    assign o_cnt = r_cnt;
endmodule

// File: rtl/char_ram_arbiter.sv
// char_ram_arbiter: shares one single-port character RAM between the video scan and update writes;
// video wins unless a write has starved for STARVE_LIMIT cycles, in which case the read is returned stale.
module char_ram_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W       = VGA_ADDR_W,
    parameter int DATA_W       = VGA_DATA_W,
    parameter int STARVE_LIMIT = VGA_STARVE_LIMIT
) (
    input logic             clk,
    input logic             rst_n,
    char_ram_arbiter_if.slave bus
);
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
    logic [WAIT_W-1:0] w_wait;
    logic              w_force, w_read, w_norm, w_wr;
    arb_state_t        r_state;
    logic              r_disp, r_p2_v, r_p2_s;
    // Requiring wr_ack=0 on every grant spaces writes two cycles apart, so held data is never rewritten.
    assign w_force = bus.wr_req && !bus.wr_ack && (w_wait == WAIT_W'(STARVE_LIMIT));
    assign w_read  = bus.vid_rd_en && !w_force;
    assign w_norm  = !bus.vid_rd_en && bus.wr_req && !bus.wr_ack;
    assign w_wr    = w_force || w_norm;
    sat_counter #(.W(WAIT_W), .LIMIT(STARVE_LIMIT)) u_wait (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (bus.wr_req),
        .i_clr (w_wr || !bus.wr_req),
        .o_cnt (w_wait)
    );
    sat_counter #(.W(FCNT_W), .LIMIT(65535)) u_forced (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_force),
        .i_clr (1'b0),
        .o_cnt (bus.forced_cnt)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state       <= IDLE;
            r_disp        <= 1'b0;
            r_p2_v        <= 1'b0;
            r_p2_s        <= 1'b0;
            bus.mem_addr  <= {ADDR_W{1'b0}};
            bus.mem_wdata <= {DATA_W{1'b0}};
            bus.mem_we    <= 1'b0;
            bus.wr_ack    <= 1'b0;
            bus.vid_data  <= {DATA_W{1'b0}};
            bus.vid_valid <= 1'b0;
            bus.vid_stale <= 1'b0;
        end else begin
            r_state       <= w_force ? FORCE : w_read ? READ : w_norm ? WRITE : IDLE;
            r_disp        <= w_force && bus.vid_rd_en;
            bus.mem_we    <= w_wr;
            bus.wr_ack    <= w_wr;
            if (w_wr) begin
                bus.mem_addr  <= bus.wr_addr;
                bus.mem_wdata <= bus.wr_data;
            end else if (w_read)
                bus.mem_addr  <= bus.vid_addr;
            // RAM output lands one cycle after the address, so the return is sampled one stage later.
            r_p2_v        <= (r_state == READ) || r_disp;
            r_p2_s        <= r_disp;
            bus.vid_valid <= r_p2_v;
            bus.vid_stale <= r_p2_v && r_p2_s;
            if (r_p2_v && !r_p2_s)
                bus.vid_data <= bus.mem_rdata;
        end
endmodule

// File: doc/char_ram_arbiter.md
CHAR_RAM_ARBITER -- requirements
Module: char_ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12: character-cell address width (80x30 text grid).
REQ-002 Parameter DATA_W, default 8: character code width.
REQ-003 Parameter STARVE_LIMIT, default 800: wait cycles before a write is forced (one line of pixel clocks).
REQ-004 clk  input  1  pixel clock; single clock domain, all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 vid_rd_en  input  1  video scan read request, one cycle per read.
REQ-007 vid_addr  input  ADDR_W  video read cell address.
REQ-008 vid_data  output  DATA_W  character returned to video path.
REQ-009 vid_valid  output  1  vid_data valid this cycle.
REQ-010 vid_stale  output  1  read was dropped; vid_data repeats the previous value.
REQ-011 wr_req  input  1  write request from the word-generator/update logic.
REQ-012 wr_addr  input  ADDR_W  write cell address.
REQ-013 wr_data  input  DATA_W  character to write.
REQ-014 wr_ack  output  1  one-cycle pulse: write issued.
REQ-015 mem_addr  output  ADDR_W  registered address to single-port RAM.
REQ-016 mem_wdata  output  DATA_W  registered write data to RAM.
REQ-017 mem_we  output  1  registered write enable to RAM.
REQ-018 mem_rdata  input  DATA_W  RAM read data, valid one cycle after mem_addr is presented.
REQ-019 forced_cnt  output  16  count of forced writes, saturating at 16'hFFFF.

Function
REQ-020 The block SHALL make one grant decision per cycle from sampled vid_rd_en, wr_req, wr_ack and the wait counter.
REQ-021 Decision priority: forced write > video read > normal write > idle.
REQ-022 Video read grant: mem_addr<=vid_addr, mem_we<=0; vid_data<=mem_rdata with vid_valid=1, vid_stale=0 exactly 2 cycles after the vid_rd_en sample edge.
REQ-023 Normal write grant SHALL occur only when vid_rd_en=0, wr_req=1 and wr_ack=0: mem_addr<=wr_addr, mem_wdata<=wr_data, mem_we<=1 and wr_ack=1 for exactly one cycle, both on the next edge.
REQ-024 Because grants require wr_ack=0, back-to-back writes SHALL be at most one per 2 cycles; a held wr_req SHALL never write the same data twice.
REQ-025 wr_addr/wr_data SHALL be sampled only at grant; requester holds them stable while wr_req=1 and wr_ack=0.
REQ-026 Wait counter: increments each cycle wr_req=1 and no write is granted; cleared on any write grant or when wr_req=0; saturates at STARVE_LIMIT.
REQ-027 When wait counter = STARVE_LIMIT and wr_ack=0, a forced write SHALL be granted even if vid_rd_en=1; forced_cnt increments (saturating).
REQ-028 A video read displaced by a forced write SHALL still produce vid_valid=1 two cycles later, with vid_stale=1 and vid_data holding its previous value.
REQ-029 mem_we SHALL be high only in the cycle following a write grant; otherwise 0.
REQ-030 FSM states: IDLE, READ, WRITE, FORCE (state of the registered memory cycle); any state transitions to any state per REQ-021 each cycle.
REQ-031 Address wrap: no range check; addresses >= 2400 pass to the RAM unchanged.

Reset
REQ-032 On rst_n=0, immediately: state=IDLE, mem_we=0, mem_addr=0, mem_wdata=0, wr_ack=0, vid_valid=0, vid_stale=0, vid_data=0, wait counter=0, forced_cnt=0.
REQ-033 Reset mid-write SHALL drop mem_we at once; the write is not acknowledged and not retried; pending read returns are discarded.
REQ-034 First grant decision SHALL occur at the first rising edge after rst_n deasserts.

Structure
REQ-035 Package vga_pkg SHALL hold ADDR_W/DATA_W defaults, STARVE_LIMIT default and the arbiter state enum.
REQ-036 One sub-module, sat_counter (parameterised width/limit, inc/clear), SHALL implement both the wait counter and forced_cnt.

Verification
REQ-037 vid_rd_en=1, vid_addr=12'h005, RAM[5]=8'h41 -> vid_valid=1, vid_data=8'h41, vid_stale=0 two cycles later.
REQ-038 wr_req=1, wr_addr=12'h010, wr_data=8'h5A, vid_rd_en=0 -> next cycle mem_we=1, mem_addr=12'h010, wr_ack one-cycle pulse; RAM[16]=8'h5A.
REQ-039 wr_req held high for 4 writes with vid_rd_en=0 -> wr_ack pulses every 2nd cycle, exactly 4 mem_we pulses.
REQ-040 vid_rd_en=1 continuously, wr_req=1 -> write forced after exactly 800 wait cycles; displaced read returns vid_stale=1 with prior data; forced_cnt=1.
REQ-041 rst_n pulsed low in the cycle mem_we=1 -> mem_we, wr_ack, vid_valid 0 asynchronously; forced_cnt=0; normal operation resumes after release.
